// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for uart_rx_fc.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int CLK_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/uart_rx_fc.sv
// UART receiver (8N1) with FWFT receive FIFO and RTS flow control with hysteresis.
// Define UART_RX_PARITY_EN for 8E1 framing and the o_parity_err pulse.
module uart_rx_fc
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_uart_rx,
  output logic                 o_uart_rts_n,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_overrun
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CW-1:0]    RTS_ON   = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0]    RTS_OFF  = CW'(FIFO_DEPTH / 2);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2, r_rx_d;
  rx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]           r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_brk, w_brk_nxt;
  logic                 w_rx, w_fall, w_expired;
  logic                 w_push, w_ferr, w_pop, w_full, w_empty;
  logic [CW-1:0]        w_count;
  logic                 r_rts_n, r_frame_err, r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad, w_par_bad_nxt, w_perr, r_parity_err;
`endif

  // Third flop only provides the previous synchronized level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_rx      = r_sync2;
  assign w_fall    = r_rx_d && !r_sync2;
  assign w_expired = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_brk_nxt   = r_brk;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_BIT;
        end
      end
      START: begin
        if (!w_expired) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (!w_rx) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = FULL_BIT;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!w_expired) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          w_cnt_nxt   = FULL_BIT;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!w_expired) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_par_bad_nxt = (^r_shift) ^ w_rx;
          w_cnt_nxt     = FULL_BIT;
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        // After a framing error, hold here until the line is idle again.
        if (r_brk) begin
          if (w_rx) begin
            w_state_nxt = IDLE;
            w_brk_nxt   = 1'b0;
          end
        end else if (!w_expired) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (!w_rx) begin
          w_ferr    = 1'b1;
          w_brk_nxt = 1'b1;
        end else begin
`ifdef UART_RX_PARITY_EN
          if (r_par_bad) w_perr = 1'b1;
          else           w_push = 1'b1;
`else
          w_push = 1'b1;
`endif
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_brk   <= w_brk_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  assign w_pop = !w_empty && i_ready;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (o_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rts_n     <= 1'b1;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_count >= RTS_ON)       r_rts_n <= 1'b1;
      else if (w_count <= RTS_OFF) r_rts_n <= 1'b0;
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_perr;
`endif
    end
  end

  assign o_valid      = !w_empty;
  assign o_uart_rts_n = r_rts_n;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule
